// File: rtl/uart16550_rx.sv
// UART receive engine: oversampled start/data/parity/stop recovery with break
// detection, emitting one {bi, fe, pe, d[7:0]} Rx FIFO word per character.
module uart16550_rx #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MAJORITY    = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        baud_tick_i,
    input  logic        sin_i,
    input  logic [1:0]  wls_i,
    input  logic        pen_i,
    input  logic        eps_i,
    input  logic        stick_parity_i,
    output logic        rx_we_o,
    output logic [10:0] rx_d_o,
    output logic        busy_o
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] CNT_RES  = (MAJORITY != 0) ? CW'(OVERSAMPLE / 2 + 1) : CNT_MID;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             d_q, d_d;
    logic [1:0]             samp_q, samp_d;
    logic [1:0]             wls_q, wls_d;
    logic                   pen_q, pen_d;
    logic                   eps_q, eps_d;
    logic                   stick_q, stick_d;
    logic                   par_bit_q, par_bit_d;
    logic                   pe_q, pe_d;
    logic                   rx_we_q, rx_we_d;
    logic [10:0]            rx_d_q, rx_d_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    logic sin_s;
    logic bit_val;
    logic resolve;
    logic wrap;
    logic exp_par;
    logic stop_bi;

    assign sin_s   = sync_q[SYNC_STAGES-1];
    // samp_q[1] holds the pre-centre sample, samp_q[0] the centre sample.
    assign bit_val = (MAJORITY != 0)
                   ? ((samp_q[1] & samp_q[0]) | (samp_q[1] & sin_s) | (samp_q[0] & sin_s))
                   : sin_s;
    assign resolve = baud_tick_i && (cnt_q == CNT_RES);
    assign wrap    = (cnt_q == CNT_LAST);
    assign exp_par = stick_q ? ~eps_q : (^d_q ^ eps_q ^ 1'b1);
    assign stop_bi = (d_q == 8'h00) && (!pen_q || !par_bit_q) && !bit_val;

    // NOTE: every _d gets its hold value first so no path leaves a latch behind.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        d_d       = d_q;
        samp_d    = samp_q;
        wls_d     = wls_q;
        pen_d     = pen_q;
        eps_d     = eps_q;
        stick_d   = stick_q;
        par_bit_d = par_bit_q;
        pe_d      = pe_q;
        rx_we_d   = 1'b0;
        rx_d_d    = rx_d_q;
        sync_d    = {sync_q[SYNC_STAGES-2:0], sin_i};

        if (baud_tick_i) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_PRE) samp_d[1] = sin_s;
            if (cnt_q == CNT_MID) samp_d[0] = sin_s;

            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (!sin_s) begin
                        state_d   = ST_START;
                        cnt_d     = CW'(1);
                        idx_d     = 3'd0;
                        d_d       = 8'h00;
                        pe_d      = 1'b0;
                        par_bit_d = 1'b0;
                        wls_d     = wls_i;
                        pen_d     = pen_i;
                        eps_d     = eps_i;
                        stick_d   = stick_parity_i;
                    end
                end
                ST_START: begin
                    if (resolve && bit_val) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (wrap) begin
                        state_d = ST_DATA;
                        idx_d   = 3'd0;
                    end
                end
                ST_DATA: begin
                    if (resolve) d_d[idx_q] = bit_val;
                    if (wrap) begin
                        if (idx_q == ({1'b0, wls_q} + 3'd4)) begin
                            state_d = pen_q ? ST_PARITY : ST_STOP;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (resolve) begin
                        par_bit_d = bit_val;
                        pe_d      = (bit_val != exp_par);
                    end
                    if (wrap) state_d = ST_STOP;
                end
                ST_STOP: begin
                    // Leaving at mid-stop lets a following start bit be seen early.
                    if (resolve) begin
                        rx_we_d = 1'b1;
                        rx_d_d  = {stop_bi, ~bit_val, pe_q, d_q};
                        state_d = stop_bi ? ST_BRK : ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_BRK: begin
                    cnt_d = '0;
                    if (sin_s) state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // NOTE: state updates use <= so every flop samples the pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            d_q       <= 8'h00;
            samp_q    <= 2'b11;
            wls_q     <= 2'b00;
            pen_q     <= 1'b0;
            eps_q     <= 1'b0;
            stick_q   <= 1'b0;
            par_bit_q <= 1'b0;
            pe_q      <= 1'b0;
            rx_we_q   <= 1'b0;
            rx_d_q    <= 11'h000;
            sync_q    <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            d_q       <= d_d;
            samp_q    <= samp_d;
            wls_q     <= wls_d;
            pen_q     <= pen_d;
            eps_q     <= eps_d;
            stick_q   <= stick_d;
            par_bit_q <= par_bit_d;
            pe_q      <= pe_d;
            rx_we_q   <= rx_we_d;
            rx_d_q    <= rx_d_d;
            sync_q    <= sync_d;
        end
    end

    assign rx_we_o = rx_we_q;
    assign rx_d_o  = rx_d_q;
    assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart16550_rx.sv
// Self-checking bench for uart16550_rx: directed frames from the test plan plus
// randomized frames scored against a character-level reference model.
`timescale 1ns/1ps
module tb_uart16550_rx;

    localparam int OS   = 16;
    localparam int SYNC = 2;
    localparam int MAJ  = 1;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        baud_tick_i;
    logic        sin_i;
    logic [1:0]  wls_i;
    logic        pen_i;
    logic        eps_i;
    logic        stick_parity_i;
    logic        rx_we_o;
    logic [10:0] rx_d_o;
    logic        busy_o;

    uart16550_rx #(
        .OVERSAMPLE (OS),
        .SYNC_STAGES(SYNC),
        .MAJORITY   (MAJ)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .baud_tick_i   (baud_tick_i),
        .sin_i         (sin_i),
        .wls_i         (wls_i),
        .pen_i         (pen_i),
        .eps_i         (eps_i),
        .stick_parity_i(stick_parity_i),
        .rx_we_o       (rx_we_o),
        .rx_d_o        (rx_d_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int tick_period = 1;
    int cyc = 0;
    int start_cyc = 0;
    int push_cyc = 0;
    logic busy_at_push = 1'b0;
    int busy_total = 0;
    int rd_idx = 0;
    logic [10:0] got_q[$];
    logic [10:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle with rx_we_o high is one recorded push.
    always @(negedge clk) begin
        if (rx_we_o) begin
            got_q.push_back(rx_d_o);
            push_cyc     = cyc;
            busy_at_push = busy_o;
        end
        if (busy_o) busy_total = busy_total + 1;
    end

    // Baud tick generator: one pulse every tick_period clocks.
    initial begin
        int tcnt = 0;
        baud_tick_i = 1'b0;
        forever begin
            @(negedge clk);
            tcnt++;
            baud_tick_i = ((tcnt % tick_period) == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!baud_tick_i);
        end
        #1;
    endtask

    function automatic logic good_parity(input logic [7:0] d, input logic eps, input logic stick);
        int ones = $countones(d);
        if (stick) return !eps;
        // Even parity makes the total count of ones even, odd parity makes it odd.
        if (eps) return (ones % 2) == 1;
        return (ones % 2) == 0;
    endfunction

    function automatic logic [10:0] model_word(input logic [7:0] data, input logic [1:0] wls,
                                               input logic pen, input logic eps, input logic stick,
                                               input logic par, input logic stop);
        int nbits = int'(wls) + 5;
        logic [7:0] d = 8'(int'(data) & ((1 << nbits) - 1));
        logic pe = pen && (par != good_parity(d, eps, stick));
        logic fe = !stop;
        logic bi = (d == 8'h00) && (!pen || !par) && !stop;
        return {bi, fe, pe, d};
    endfunction

    task automatic send_frame(input logic [7:0] data, input logic [1:0] wls, input logic pen,
                              input logic eps, input logic stick, input logic par,
                              input logic stop, input int spike_bit, input bit scramble);
        int nbits = int'(wls) + 5;
        wls_i = wls; pen_i = pen; eps_i = eps; stick_parity_i = stick;
        sin_i = 1'b0;
        start_cyc = cyc;
        wait_ticks(OS / 2);
        if (scramble) begin
            wls_i = 2'($urandom); pen_i = 1'($urandom);
            eps_i = 1'($urandom); stick_parity_i = 1'($urandom);
        end
        wait_ticks(OS / 2);
        for (int i = 0; i < nbits; i++) begin
            sin_i = data[i];
            if (i == spike_bit) begin
                wait_ticks(OS / 2);
                sin_i = ~data[i];
                wait_ticks(1);
                sin_i = data[i];
                wait_ticks(OS / 2 - 1);
            end else begin
                wait_ticks(OS);
            end
        end
        if (pen) begin
            sin_i = par;
            wait_ticks(OS);
        end
        sin_i = stop;
        wait_ticks(OS);
        sin_i = 1'b1;
    endtask

    task automatic expect_pushes(input string tag);
        int n_got = got_q.size() - rd_idx;
        check({tag, ":count"}, n_got, exp_q.size());
        while (exp_q.size() > 0) begin
            if (rd_idx < got_q.size()) begin
                check({tag, ":word"}, {21'd0, got_q[rd_idx]}, {21'd0, exp_q[0]});
                rd_idx++;
            end
            void'(exp_q.pop_front());
        end
        rd_idx = got_q.size();
    endtask

    task automatic idle_gap(input int bits);
        sin_i = 1'b1;
        wait_ticks(bits * OS);
    endtask

    initial begin
        int b0;
        rst_i = 1'b1; sin_i = 1'b1;
        wls_i = 2'b00; pen_i = 1'b0; eps_i = 1'b0; stick_parity_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst:we", rx_we_o, 0);
        check("rst:d", rx_d_o, 0);
        check("rst:busy", busy_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        idle_gap(2);

        // 8N1 0xA5, one tick per clock: latency and busy at push.
        tick_period = 1;
        idle_gap(1);
        send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        idle_gap(2);
        exp_q.push_back(11'h0A5);
        expect_pushes("8n1_a5");
        check("8n1_a5:latency", push_cyc - start_cyc, 153 + SYNC + 1);
        check("8n1_a5:busy_at_push", busy_at_push, 0);
        check("8n1_a5:hold", rx_d_o, 11'h0A5);

        // 7E1 0x3C with wrong then correct parity bit.
        send_frame(8'h3C, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        idle_gap(2);
        exp_q.push_back(11'h13C);
        expect_pushes("7e1_bad");
        send_frame(8'h3C, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        idle_gap(2);
        exp_q.push_back(11'h03C);
        expect_pushes("7e1_good");

        // Framing error then a clean frame.
        send_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        idle_gap(2);
        exp_q.push_back(11'h255);
        expect_pushes("fe_55");
        send_frame(8'h12, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        idle_gap(2);
        exp_q.push_back(11'h012);
        expect_pushes("after_fe_12");

        // Break: 20 bit times low, exactly one push, held in BRK until line high.
        wls_i = 2'b11; pen_i = 1'b0;
        sin_i = 1'b0;
        wait_ticks(20 * OS);
        check("brk:busy_low", busy_o, 1);
        exp_q.push_back(11'h600);
        expect_pushes("brk");
        idle_gap(2);
        check("brk:busy_after", busy_o, 0);
        send_frame(8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        idle_gap(2);
        exp_q.push_back(11'h081);
        expect_pushes("after_brk_81");

        // Glitch: short low pulse is a false start.
        b0 = busy_total;
        sin_i = 1'b0;
        wait_ticks(3);
        sin_i = 1'b1;
        idle_gap(2);
        check("glitch:busy_seen", (busy_total - b0) > 0, 1);
        check("glitch:busy_len", (busy_total - b0) <= OS / 2 + 1, 1);
        check("glitch:busy_end", busy_o, 0);
        expect_pushes("glitch");

        // Single-tick spikes at the centre of data bit 3 are voted out.
        send_frame(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0);
        idle_gap(2);
        exp_q.push_back(11'h000);
        expect_pushes("spike_00");
        send_frame(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0);
        idle_gap(2);
        exp_q.push_back(11'h0FF);
        expect_pushes("spike_ff");

        // 5-bit stick parity, eps=1, parity bit 0.
        send_frame(8'h15, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        idle_gap(2);
        exp_q.push_back(11'h015);
        expect_pushes("stick5_15");

        // Reset in the middle of data bit 2 of the next frame.
        sin_i = 1'b0;
        wait_ticks(OS);
        sin_i = 1'b0; wait_ticks(OS);
        sin_i = 1'b1; wait_ticks(OS);
        sin_i = 1'b1; wait_ticks(OS / 2);
        check("mid_rst:busy_before", busy_o, 1);
        rst_i = 1'b1;
        sin_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_rst:we", rx_we_o, 0);
        check("mid_rst:d", rx_d_o, 0);
        check("mid_rst:busy", busy_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        idle_gap(2);
        expect_pushes("mid_rst");
        send_frame(8'h0A, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        idle_gap(2);
        exp_q.push_back(11'h00A);
        expect_pushes("after_rst_0a");

        // Randomized frames against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] data  = 8'($urandom);
            logic [1:0] wls   = 2'($urandom);
            logic       pen   = 1'($urandom);
            logic       eps   = 1'($urandom);
            logic       stick = 1'($urandom);
            logic       par;
            logic       stop  = ($urandom_range(0, 3) != 0);
            int         nb    = int'(wls) + 5;
            if ($urandom_range(0, 7) == 0) data = 8'h00;
            par = good_parity(8'(int'(data) & ((1 << nb) - 1)), eps, stick) ^ ($urandom_range(0, 2) == 0);
            tick_period = $urandom_range(1, 3);
            idle_gap(1);
            send_frame(data, wls, pen, eps, stick, par, stop, -1, 1'b1);
            idle_gap(2);
            exp_q.push_back(model_word(data, wls, pen, eps, stick, par, stop));
            expect_pushes($sformatf("rand%0d", n));
            check($sformatf("rand%0d:idle", n), busy_o, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart16550_rx.md
Name: uart16550_rx

Overview:
- Parametrised UART receive engine for the uart16550 core: oversampled start/data/parity/stop recovery, word lengths 5–8, normal or stick parity, break detection.
- Sits between the synchronised-in sin pin and the Rx FIFO write port.
- Produces one FIFO word per received character in the Rx FIFO format {bi, fe, pe, d[7:0]}.
- Successor to the fixed-16x receiver: generalises oversample rate, synchroniser depth and sampling mode (single or majority-of-3).

Parameters:
- OVERSAMPLE, 16, baud ticks per bit; even, >=4.
- SYNC_STAGES, 2, sin synchroniser depth; >=2.
- MAJORITY, 1, 1 = majority of 3 samples at bit centre; 0 = single centre sample.

Ports:
- clk_i  input  1  core clock.
- rst_i  input  1  synchronous reset, active-high.
- baud_tick_i  input  1  one-cycle pulse, OVERSAMPLE pulses per bit time.
- sin_i  input  1  asynchronous serial input, idle high.
- wls_i  input  2  word length: 00=5, 01=6, 10=7, 11=8 bits.
- pen_i  input  1  parity enable.
- eps_i  input  1  1 = even parity, 0 = odd parity.
- stick_parity_i  input  1  stick parity enable.
- rx_we_o  output  1  one-cycle Rx FIFO push strobe.
- rx_d_o  output  11  {bi, fe, pe, d[7:0]}; valid while rx_we_o=1.
- busy_o  output  1  a frame is in progress (state != IDLE).

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high (rst_i).
- Reset values:
  - rx_we_o=0, rx_d_o=0, busy_o=0, state=IDLE.
  - Synchroniser flops = 1.
  - Sample counter cnt=0, bit index=0.
- Timing: all datapath activity advances only on cycles where baud_tick_i=1; rx_we_o is the only per-clock event.
- Synchroniser: sin_i passes through SYNC_STAGES flops; s = last stage.
- Sample point:
  - cnt runs 0..OVERSAMPLE-1 per bit and wraps to 0.
  - MAJORITY=1: samples taken at cnt = OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1 (7,8,9 at 16x); bit value = majority, resolved at the last of the three.
  - MAJORITY=0: single sample at cnt = OVERSAMPLE/2.
  - "Bit resolve tick" = the tick where the bit value is decided.
- Configuration: wls_i, pen_i, eps_i and stick_parity_i are latched on the IDLE->START transition. Changes mid-frame have no effect until the next frame.
- States:
  - IDLE: on tick with s=0 -> START, cnt=1.
  - START: at resolve, bit=1 -> IDLE (false start, no push, no flags). Otherwise continue; at cnt wrap -> DATA, bit index=0.
  - DATA: at resolve, d[idx]=bit, LSB first. After bit wls+4 (i.e. idx = wls+4) wraps -> PARITY if pen, else STOP. d bits above the word length are 0.
  - PARITY:
    - Expected bit: stick=1 -> expected = ~eps; stick=0 -> expected = ^d ^ eps ^ 1 (even: data^parity=0).
    - pe = received != expected.
    - At cnt wrap -> STOP.
  - STOP:
    - Only the first stop bit is checked; stop bits beyond the first are not checked, so no stop-bit-count input exists.
    - At resolve: fe = ~bit.
    - bi = (d==0) & (parity bit==0 or !pen) & stop bit==0.
    - Push the word, then -> IDLE if !bi, or -> BRK if bi.
    - Returning to IDLE at mid-stop allows a following start bit to be detected half a bit early.
  - BRK: word already pushed as {bi=1, fe=1, pe, d=0}. Remain until a tick with s=1, then -> IDLE. Exactly one push per break, however long the break lasts.
- Push timing: rx_we_o=1 for exactly one clk_i cycle, the cycle after the stop-bit resolve tick. rx_d_o is registered and holds its value until the next push.
- No backpressure: the FIFO owns overrun detection.
- rst_i mid-frame: immediate return to reset values; no push for the partial frame.
- baud_tick_i held high every cycle is legal; the block then runs at one sample per clock.

Test Plan:
- 8N1, data 0xA5, OVERSAMPLE=16, tick every clock -> one rx_we_o pulse at clk 153 after start edge ±SYNC latency; rx_d_o=0x0A5; busy_o falls at stop centre.
- 7E1, data 0x3C sent with parity bit 1 (wrong) -> rx_d_o = {bi=0, fe=0, pe=1, d=0x3C}; resent with parity 0 -> pe=0.
- 8N1, data 0x55 with stop bit driven 0 -> rx_d_o = {0, fe=1, 0, 0x55}; next valid frame 0x12 received cleanly.
- Break: sin low for 20 bit times, then high, then frame 0x81 -> exactly two pushes: 0x600 then 0x081.
- Glitch: sin low for 3 ticks, then high -> no push; busy_o high for ≤ OVERSAMPLE/2+1 ticks then 0. With MAJORITY=1, a single-tick high spike at the centre of data bit 3 of 0x00 -> d=0x00.
- 5-bit stick parity eps=1, data 0x15, parity bit 0 -> pe=0, d=0x15. Then rst_i asserted at data bit 2 of the next frame -> no push; outputs return to 0; next frame received normally.
